// File: rtl/sram_port_arbiter_if.sv
// Request, response and SRAM macro signals of the SRAM port arbiter.
// The arbiter connects to the slave modport; clients and the macro model use the master modport.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned REQ_ID_W   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [REQ_ID_W-1:0]           grant_id;
  logic                          busy;
  logic [ADDR_WIDTH-1:0]         sram_address;
  logic                          sram_enable;
  logic                          sram_read;
  logic                          sram_write;
  logic [DATA_WIDTH-1:0]         sram_wdata;
  logic                          sram_data_oe;
  logic [DATA_WIDTH-1:0]         sram_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, sram_rdata,
    output grant, done, rdata, grant_id, busy,
    output sram_address, sram_enable, sram_read, sram_write, sram_wdata, sram_data_oe
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, sram_rdata,
    input  grant, done, rdata, grant_id, busy,
    input  sram_address, sram_enable, sram_read, sram_write, sram_wdata, sram_data_oe
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter that sequences one single-port SDR SRAM between NUM_REQ requesters.
// Each op runs IDLE -> SETUP -> ACCESS -> CAPTURE -> COMPLETE with all outputs registered.
module sram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned REQ_ID_W   = 2
) (
  input logic                clk,
  input logic                rst_n,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StCapture,
    StComplete
  } state_e;

  state_e                state_q;
  logic [REQ_ID_W-1:0]   ptr_q;
  logic [REQ_ID_W-1:0]   cur_id_q;
  logic                  cur_write_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic [NUM_REQ-1:0]    done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  enable_q;
  logic                  read_q;
  logic                  write_q;
  logic                  oe_q;

  logic                  sel_found;
  logic [REQ_ID_W-1:0]   sel_id;
  logic [REQ_ID_W-1:0]   idx;

  // Circular search starting at the round-robin pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = REQ_ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!sel_found && bus.req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      cur_write_q <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      enable_q    <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            cur_id_q    <= sel_id;
            cur_write_q <= bus.req_write[sel_id];
            addr_q      <= bus.req_addr[32'(sel_id)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q     <= bus.req_wdata[32'(sel_id)*DATA_WIDTH +: DATA_WIDTH];
            oe_q        <= bus.req_write[sel_id];
            grant_q     <= NUM_REQ'(1) << sel_id;
            busy_q      <= 1'b1;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          enable_q <= 1'b1;
          read_q   <= !cur_write_q;
          write_q  <= cur_write_q;
          state_q  <= StAccess;
        end
        StAccess: begin
          enable_q <= 1'b0;
          read_q   <= 1'b0;
          write_q  <= 1'b0;
          oe_q     <= 1'b0;
          state_q  <= StCapture;
        end
        StCapture: begin
          // Macro data is valid for the whole cycle after the read edge.
          if (!cur_write_q) begin
            rdata_q <= bus.sram_rdata;
          end
          done_q  <= grant_q;
          state_q <= StComplete;
        end
        StComplete: begin
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (cur_id_q == REQ_ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.rdata        = rdata_q;
  assign bus.grant_id     = cur_id_q;
  assign bus.busy         = busy_q;
  assign bus.sram_address = addr_q;
  assign bus.sram_enable  = enable_q;
  assign bus.sram_read    = read_q;
  assign bus.sram_write   = write_q;
  assign bus.sram_wdata   = wdata_q;
  assign bus.sram_data_oe = oe_q;

endmodule
